// File: rtl/i2c_rx_seq_if.sv
// Command, receiver and output-stream signals of the i2c_rx transaction sequencer.
interface i2c_rx_seq_if #(
    parameter int LW = 5
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len;
    logic          rx_start_n;
    logic          rx_ack;
    logic [7:0]    rx_data;
    logic          rx_data_rdy_n;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output cmd_valid, cmd_len, rx_data, rx_data_rdy_n, out_ready,
        input  cmd_ready, rx_start_n, rx_ack, out_data, out_valid
    );

    modport slave (
        input  cmd_valid, cmd_len, rx_data, rx_data_rdy_n, out_ready,
        output cmd_ready, rx_start_n, rx_ack, out_data, out_valid
    );
endinterface

// File: rtl/i2c_rx_seq.sv
// Read-transaction sequencer for i2c_rx: drives start/ack, collects bytes into a FIFO.
// Optional inter-byte watchdog enabled by defining I2C_RX_SEQ_TIMEOUT_EN.
module i2c_rx_seq #(
    parameter int DEPTH          = 16,
    parameter int LW             = $clog2(DEPTH + 1),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rstn,
    i2c_rx_seq_if.slave  bus,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("i2c_rx_seq: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_RECV, S_DONE} state_t;

    state_t        state, state_nx;
    logic [LW-1:0] remaining, remaining_nx;
    logic [LW-1:0] count, free;
    logic [PW-1:0] wptr, rptr;
    logic [7:0]    mem [DEPTH];
    logic          rdy_q, capture, push, pop, cmd_fire, timeout;
    logic          start_n_q, start_n_nx;

    assign free          = LW'(DEPTH) - count;
    assign bus.cmd_ready = (state == S_IDLE) && (free >= bus.cmd_len);
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
    // A byte is taken only on the falling edge of the ready strobe, and only while receiving.
    assign capture       = (state == S_RECV) && !bus.rx_data_rdy_n && rdy_q;
    assign push          = capture;
    assign pop           = bus.out_valid && bus.out_ready;

    assign bus.rx_start_n = start_n_q;
    assign bus.rx_ack     = !((state == S_RECV) && (remaining > LW'(1)));
    assign bus.out_valid  = (count != '0);
    assign bus.out_data   = bus.out_valid ? mem[rptr] : 8'h00;
    assign busy           = (state == S_START) || (state == S_RECV);
    assign done           = (state == S_DONE);

`ifdef I2C_RX_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt;
    logic          err_q;

    assign timeout = (state == S_RECV) && !capture && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state != S_RECV || capture) wd_cnt <= '0;
            else                            wd_cnt <= wd_cnt + TW'(1);
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        start_n_nx   = 1'b1;
        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    remaining_nx = bus.cmd_len;
                    state_nx     = (bus.cmd_len == '0) ? S_DONE : S_START;
                end
            end
            S_START: state_nx = S_RECV;
            S_RECV: begin
                if (capture) begin
                    remaining_nx = remaining - LW'(1);
                    if (remaining == LW'(1)) state_nx = S_DONE;
                end else if (timeout) begin
                    remaining_nx = '0;
                    state_nx     = S_IDLE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        // rx_start_n is registered from the upcoming state so it lines up with that state.
        if (state_nx == S_START)     start_n_nx = 1'b0;
        else if (state_nx == S_RECV) start_n_nx = (remaining_nx == LW'(1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            remaining <= '0;
            start_n_q <= 1'b1;
            rdy_q     <= 1'b1;
        end else begin
            state     <= state_nx;
            remaining <= remaining_nx;
            start_n_q <= start_n_nx;
            rdy_q     <= bus.rx_data_rdy_n;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.rx_data;
    end
endmodule

// File: doc/i2c_rx_seq.md
# i2c_rx_seq

Transaction sequencer for the `i2c_rx` byte receiver. It accepts a read command of N bytes and drives the receiver's active-low start and acknowledge inputs: ACK on every byte except the last, NACK on the last. Received bytes are collected into an internal FIFO and handed downstream over a valid/ready stream. It sits between the host command logic and `i2c_rx`.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `LW`, `$clog2(DEPTH+1)`: width of `cmd_len`.
- `TIMEOUT_CYCLES`, 64: inter-byte watchdog limit; only used with `I2C_RX_SEQ_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic on posedge.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `cmd_valid` in 1: read command request.
- `cmd_ready` out 1: command can be accepted.
- `cmd_len` in LW: bytes to read, 0..DEPTH.
- `rx_start_n` out 1: to the receiver's `rx` input; low = start/continue receive.
- `rx_ack` out 1: to the receiver's `ack`; 0 = ACK, 1 = NACK.
- `rx_data` in 8: receiver byte.
- `rx_data_rdy_n` in 1: receiver byte-ready, active-low.
- `out_data` out 8: FIFO head.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: downstream accept.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `err` out 1: one-cycle pulse on timeout (macro builds only; tied 0 otherwise).

## Operation
- **States:**
  - IDLE → START on a command handshake.
  - START → RECV after 1 cycle.
  - RECV → DONE when the last byte is pushed.
  - DONE → IDLE after 1 cycle.
- **Command acceptance:**
  - `cmd_ready` = (state==IDLE) && (free slots ≥ `cmd_len`).
  - The FIFO therefore never overflows and the receiver is never stalled.
- **`cmd_len`==0:** the handshake goes IDLE → DONE directly, with no bus activity and no START.
- **`remaining` counter (LW bits):**
  - Loaded with `cmd_len` on the handshake.
  - Decrements on each captured byte.
  - Never underflows: bytes arriving outside RECV are ignored.
- **`rx_start_n` (registered):**
  - 1 in IDLE and DONE.
  - 0 in START.
  - In RECV, equals (`remaining`==1).
- **`rx_ack`:** 1 in every state except RECV with `remaining`>1, where it is 0.
- **Byte capture:**
  - `rx_data_rdy_n` passes through one flop (`rdy_q`).
  - Capture happens when `rx_data_rdy_n`==0 && `rdy_q`==1, i.e. on the falling edge. Exactly one push per byte, whatever the low-pulse length.
  - The captured byte is pushed into the FIFO the same cycle.
- **FIFO:**
  - Pointers are log2(DEPTH) bits and wrap DEPTH-1 → 0.
  - The count is tracked separately.
  - Simultaneous push and pop is allowed at any occupancy, including full (pop frees, push fills) and empty (push only).
- `busy` = state ∈ {START, RECV}.
- **Reset (async, any state):**
  - State → IDLE; pointers, count and `remaining` → 0.
  - `rx_start_n`=1, `rx_ack`=1.
  - `busy`=0, `done`=0, `err`=0, `out_valid`=0, `cmd_ready`=1.
  - `out_data`=8'h00.
  - FIFO contents are discarded.

## Timing
- Handshake at edge T:
  - START (`rx_start_n`=0) during T+1.
  - RECV from T+2.
- Capture latency: a byte captured at edge E makes `out_valid`=1 from E+1 if the FIFO was empty; `out_data` shows the head combinationally from storage.
- Last byte captured at edge E:
  - DONE during E+1, with `done`=1 and `rx_start_n`=1.
  - IDLE at E+2, where `cmd_ready` can reassert.
- A pop happens at an edge where `out_valid`&&`out_ready`.

## Configuration
- **`I2C_RX_SEQ_TIMEOUT_EN` defined:**
  - A counter clears on START entry and on every capture, and increments in RECV.
  - Reaching `TIMEOUT_CYCLES` goes to IDLE with an `err` pulse and `rx_start_n`=1, `rx_ack`=1.
  - Bytes already in the FIFO are kept; `done` is not pulsed.
- **Undefined:** no counter, `err` is tied 0, and RECV waits indefinitely.

## Test plan
- Reset mid-RECV (len 4, after 2 bytes) → all outputs at their reset values; FIFO empty; `rx_start_n`=1.
- `cmd_len`=3, receiver model returns 8'hA5, 8'h5A, 8'h3C → `rx_ack`=0,0,1; `rx_start_n` high during byte 3; FIFO outputs the bytes in order; `done` pulses once.
- `cmd_len`=1 → START for one cycle, then `rx_ack`=1, `rx_start_n`=1 in RECV; one byte out; `done`.
- FIFO holds 14 bytes, `cmd_len`=3 with DEPTH 16 → `cmd_ready`=0 until ≥1 pop, then accepted; push/pop on the same edge at full keeps count=16.
- `cmd_len`=0 → `done` pulses 1 cycle after the handshake; `rx_start_n` stays 1.
- (macro) `cmd_len`=2, receiver silent → `err` pulse at TIMEOUT_CYCLES after START; IDLE; `done`=0.
